// File: rtl/fp_pkg.sv
// Shared FP compare definitions: op encodings, NaN detection, response payload
// and the output-register state encoding.
package fp_pkg;

  typedef enum logic [1:0] {
    OP_LT  = 2'b00,
    OP_LE  = 2'b01,
    OP_EQ  = 2'b10,
    OP_RSV = 2'b11
  } fp_op_e;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Payload captured in the output register alongside the requester id.
  typedef struct packed {
    logic result;
    logic nan;
    logic err;
  } fp_resp_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/fp_fle.sv
// IEEE-754 single-precision a <= b.
//   a, b : operands
//   le   : 1 when a <= b; 0 if either is NaN; +0 and -0 compare equal.
module fp_fle
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        le
);

  always_comb begin
    le = 1'b0;
    if (is_nan(a) || is_nan(b))        le = 1'b0;
    else if (is_zero(a) && is_zero(b)) le = 1'b1;
    else if (a[31] != b[31])           le = a[31];
    else if (!a[31])                   le = a[30:0] <= b[30:0];
    else                               le = a[30:0] >= b[30:0];
  end

endmodule

// File: rtl/fp_flt.sv
// IEEE-754 single-precision a < b.
//   a, b : operands
//   lt   : 1 when a < b; 0 if either is NaN; +0 and -0 compare equal.
module fp_flt
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  always_comb begin
    lt = 1'b0;
    if (is_nan(a) || is_nan(b))        lt = 1'b0;
    else if (is_zero(a) && is_zero(b)) lt = 1'b0;
    else if (a[31] != b[31])           lt = a[31];
    // Same sign: magnitude order, reversed for negatives.
    else if (!a[31])                   lt = a[30:0] < b[30:0];
    else                               lt = a[30:0] > b[30:0];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant selection (pure combinational).
//   valid : per-requester request
//   ptr   : index where the search starts
//   grant : one-hot of the first valid index at or after ptr (wrapping), or 0
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// Shared FP comparator fronted by a round-robin arbiter and a one-entry
// output register.
//   clk, rst          : clock, async active-high reset
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b      : per-requester IEEE-754 single operands
//   req_op            : 00 LT, 01 LE, 10 EQ, 11 reserved
//   resp_valid/ready  : output register handshake
//   resp_id           : owning requester index
//   resp_result/nan/err : comparison result, NaN seen, reserved op seen
module fp_cmp_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][31:0]      req_a,
  input  logic [N_REQ-1:0][31:0]      req_b,
  input  logic [N_REQ-1:0][1:0]       req_op,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic                        resp_result,
  output logic                        resp_nan,
  output logic                        resp_err
);

  out_state_e      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gidx;
  logic [N_REQ-1:0] arb_valid;
  logic [N_REQ-1:0] grant;
  logic            can_accept;
  logic            accept;
  logic [31:0]     sel_a, sel_b;
  logic [1:0]      sel_op;
  logic            lt, le;
  fp_resp_t        resp_d;

  // Slot is free when empty or being drained this cycle; reset blocks grants.
  assign can_accept = !rst && ((state == ST_EMPTY) || resp_ready);
  assign arb_valid  = req_valid & {N_REQ{can_accept}};

  rr_arbiter #(.N(N_REQ), .PW(ID_W)) u_rr (
    .valid (arb_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gidx = ID_W'(i);
  end

  assign sel_a  = req_a[gidx];
  assign sel_b  = req_b[gidx];
  assign sel_op = req_op[gidx];

  fp_flt u_flt (.a(sel_a), .b(sel_b), .lt(lt));
  fp_fle u_fle (.a(sel_a), .b(sel_b), .le(le));

  always_comb begin
    resp_d.nan = is_nan(sel_a) || is_nan(sel_b);
    resp_d.err = 1'b0;
    unique case (sel_op)
      OP_LT:   resp_d.result = lt;
      OP_LE:   resp_d.result = le;
      OP_EQ:   resp_d.result = le & ~lt;
      default: begin
        resp_d.result = 1'b0;
        resp_d.err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_EMPTY;
      ptr         <= '0;
      resp_id     <= '0;
      resp_result <= 1'b0;
      resp_nan    <= 1'b0;
      resp_err    <= 1'b0;
    end else if (accept) begin
      state       <= ST_FULL;
      resp_id     <= gidx;
      resp_result <= resp_d.result;
      resp_nan    <= resp_d.nan;
      resp_err    <= resp_d.err;
      ptr         <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);
    end else if (state == ST_FULL && resp_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign resp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
module tb_fp_cmp_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][31:0] req_a, req_b;
  logic [N-1:0][1:0] req_op;
  logic              resp_valid, resp_ready;
  logic [1:0]        resp_id;
  logic              resp_result, resp_nan, resp_err;

  fp_cmp_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_nan(resp_nan), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic res;
    logic nan;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;

  // Hand-computed expectation per requester, set together with its operands.
  logic [N-1:0] e_res, e_nan, e_err;

  // Bench-side reference state.
  logic       m_full = 1'b0;
  int         m_ptr  = 0;
  logic       hold_v = 1'b0;
  logic [4:0] hold_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg;
    int           gi;
    exp_t         e;
    if (rst) begin
      exp_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      hold_v = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_fields", {27'd0, resp_id, resp_result, resp_nan, resp_err}, 32'd0);
    end else begin
      chk("resp_valid_timing", 32'(resp_valid), 32'(m_full));
      if (resp_valid) begin
        if (hold_v)
          chk("hold_stable", 32'({resp_id, resp_result, resp_nan, resp_err}), 32'(hold_val));
        if (resp_ready) begin
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'(resp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_result", 32'(resp_result), 32'(e.res));
            chk("resp_nan", 32'(resp_nan), 32'(e.nan));
            chk("resp_err", 32'(resp_err), 32'(e.err));
          end
        end else begin
          hold_v   = 1'b1;
          hold_val = {resp_id, resp_result, resp_nan, resp_err};
        end
      end
      // Expected grant: first valid requester from the RR pointer, if slot free.
      eg = '0;
      gi = -1;
      if (!m_full || resp_ready)
        for (int k = 0; k < N; k++)
          if (gi < 0 && req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      if (gi >= 0) eg[gi] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(eg));
      if (gi >= 0) begin
        e.id  = 2'(gi);
        e.res = e_res[gi];
        e.nan = e_nan[gi];
        e.err = e_err[gi];
        exp_q.push_back(e);
        m_ptr  = (gi + 1) % N;
        m_full = 1'b1;
      end else if (resp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic r, input logic nn, input logic er);
    req_a[i]     = a;
    req_b[i]     = b;
    req_op[i]    = op;
    e_res[i]     = r;
    e_nan[i]     = nn;
    e_err[i]     = er;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    e_res = '0; e_nan = '0; e_err = '0;
    step(2);
    rst = 1'b0;

    // Single LT: 1.0 < 2.0
    resp_ready = 1'b1;
    set_req(0, 32'h3F800000, 32'h40000000, 2'b00, 1'b1, 1'b0, 1'b0);
    step();
    req_valid = '0;
    step(2);

    // All four requesting continuously: rotating grants, one response per cycle.
    set_req(0, 32'hC0000000, 32'hBF800000, 2'b00, 1'b1, 1'b0, 1'b0); // -2 < -1
    set_req(1, 32'h3F800000, 32'h3F800000, 2'b01, 1'b1, 1'b0, 1'b0); // 1 <= 1
    set_req(2, 32'h80000000, 32'h00000000, 2'b10, 1'b1, 1'b0, 1'b0); // -0 == +0
    set_req(3, 32'h7FC00000, 32'h3F800000, 2'b01, 1'b0, 1'b1, 1'b0); // NaN <= 1
    step(8);

    // Backpressure with new ops pending; valids toggle without grants.
    resp_ready = 1'b0;
    set_req(0, 32'h3F800000, 32'h3F800000, 2'b10, 1'b1, 1'b0, 1'b0); // 1 == 1
    set_req(1, 32'h3F800000, 32'hBF800000, 2'b00, 1'b0, 1'b0, 1'b0); // 1 < -1
    set_req(2, 32'h00000000, 32'h80000000, 2'b01, 1'b1, 1'b0, 1'b0); // +0 <= -0
    set_req(3, 32'h7F800000, 32'h7F800001, 2'b00, 1'b0, 1'b1, 1'b0); // inf < NaN
    step();
    req_valid = 4'b0101;
    step();
    req_valid = 4'b1111;
    step();
    resp_ready = 1'b1;
    step(4);
    req_valid = '0;
    step(2);

    // Reserved op from requester 2.
    set_req(2, 32'h3F800000, 32'h40000000, 2'b11, 1'b0, 1'b0, 1'b1);
    step();
    set_req(2, 32'h7FC00000, 32'h3F800000, 2'b11, 1'b0, 1'b1, 1'b1);
    step();
    req_valid = '0;
    step(2);

    // Reset while FULL: response discarded, pointer back to 0.
    resp_ready = 1'b0;
    set_req(1, 32'h40000000, 32'h3F800000, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    set_req(1, 32'h40000000, 32'h40000000, 2'b01, 1'b1, 1'b0, 1'b0); // 2 <= 2
    set_req(3, 32'h3F800000, 32'h40000000, 2'b00, 1'b1, 1'b0, 1'b0); // 1 < 2
    step(2);
    req_valid = '0;
    step(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
